simon_block_loader: RTL and testbench

SIMON_BLOCK_LOADER -- requirements
Module: simon_block_loader

---
 rtl/simon_block_loader.sv | 115 +++++++++++
 tb/tb_simon_block_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_block_loader.sv
// Byte-to-block loader for a SIMON cipher core: packs big-endian bytes into a
// 2N-bit block and offers it to the core through a one-deep holding register.
module simon_block_loader #(
    parameter int N = 48
) (
    input  logic              clk,
    input  logic              nR,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [1:0][N-1:0] inData,
    output logic              newData,
    input  logic              loadData,
    output logic [3:0]        fill_count,
    output logic              blk_pending
);
    localparam int NB = (2 * N) / 8;
    localparam int BW = 2 * N;
    localparam logic [3:0] LAST = 4'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] asm_q, asm_d;
    logic [BW-1:0] hold_q, hold_d;
    logic [BW-1:0] shifted;
    logic [3:0]    cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          pend_q, pend_d;
    logic          release_blk;
    logic          hold_free;
    logic          accept;

    assign release_blk = (state_q == OFFER) && loadData;
    assign hold_free   = !pend_q || release_blk;
    assign byte_ready  = !(full_q && pend_q && !release_blk);
    assign accept      = byte_valid && byte_ready;
    // Shifting in at the bottom leaves the first byte of a block at the top.
    assign shifted     = {asm_q[BW-9:0], byte_in};

    always_comb begin
        asm_d  = asm_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        pend_d = pend_q;
        if (release_blk) begin
            pend_d = 1'b0;
        end
        if (full_q) begin
            // A parked complete block moves on as soon as the holder frees up.
            if (hold_free) begin
                hold_d = asm_q;
                pend_d = 1'b1;
                full_d = 1'b0;
                cnt_d  = '0;
                if (accept) begin
                    asm_d = shifted;
                    cnt_d = 4'd1;
                end
            end
        end else if (accept) begin
            asm_d = shifted;
            if (cnt_q == LAST) begin
                if (hold_free) begin
                    hold_d = shifted;
                    pend_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    full_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_q) state_d = OFFER;
            OFFER:   if (loadData) state_d = GAP;
            GAP:     state_d = pend_q ? OFFER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q <= IDLE;
            asm_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
        end
    end

    assign inData      = hold_q;
    assign newData     = (state_q == OFFER);
    assign fill_count  = cnt_q;
    assign blk_pending = pend_q;

endmodule

// File: tb/tb_simon_block_loader.sv
// Directed and randomised checks of simon_block_loader: packing order, two-stage
// buffering, offer handshake, asynchronous reset behaviour and data integrity.
module tb_simon_block_loader;
    localparam int N = 48;

    logic              clk = 1'b0;
    logic              nR = 1'b1;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [1:0][N-1:0] inData;
    logic              newData;
    logic              loadData = 1'b0;
    logic [3:0]        fill_count;
    logic              blk_pending;

    int vecCount = 0;
    int errCount = 0;
    int riseCount = 0;
    int rise0;
    logic [95:0] expQ[$];
    logic [95:0] held;
    logic [95:0] rndBlk;

    simon_block_loader #(.N(N)) dut (
        .clk        (clk),
        .nR         (nR),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .inData     (inData),
        .newData    (newData),
        .loadData   (loadData),
        .fill_count (fill_count),
        .blk_pending(blk_pending)
    );

    always #5 clk = ~clk;

    always @(posedge newData) riseCount++;

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        vecCount++;
        errCount++;
        $error("[TB] FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one byte and returns 1ns after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] b);
        int  waited = 0;
        bit  done = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = byte_ready;
            tick();
            if (!done) begin
                waited++;
                if (waited > 400) begin
                    reportTimeout("byte_accept");
                    done = 1;
                end
            end
        end
    endtask

    task automatic sendBlock(input logic [95:0] blk, input int first, input int count, input bit gaps);
        for (int j = first; j < first + count; j++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            applyStimulus(blk[95 - 8*j -: 8]);
        end
        byte_valid = 1'b0;
    endtask

    task automatic waitOffer(input string tag);
        int n = 0;
        @(negedge clk);
        while (newData !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (newData !== 1'b1) reportTimeout(tag);
    endtask

    task automatic pulseReset();
        byte_valid = 1'b0;
        loadData   = 1'b0;
        #2 nR = 1'b0;
        #1 nR = 1'b1;
        tick();
    endtask

    function automatic logic [95:0] expBlock(input int k);
        logic [95:0] b = '0;
        for (int j = 0; j < 12; j++) b = {b[87:0], 4'(k), 4'(j)};
        return b;
    endfunction

    initial begin
        // Reset values appear without a clock edge.
        #1 nR = 1'b0;
        #1;
        checkOutput("rst_newData", newData, 1'b0);
        checkOutput("rst_inData", inData, 96'h0);
        checkOutput("rst_fill", fill_count, 4'd0);
        checkOutput("rst_pending", blk_pending, 1'b0);
        checkOutput("rst_ready", byte_ready, 1'b1);
        tick();
        nR = 1'b1;
        tick();
        checkOutput("rst_exit_newData", newData, 1'b0);

        // Single block, consumer answers three cycles after the offer.
        sendBlock(96'h2072616C6C69702065687420, 0, 12, 0);
        checkOutput("b1_pending", blk_pending, 1'b1);
        checkOutput("b1_fill_wrap", fill_count, 4'd0);
        checkOutput("b1_idle_cycle", newData, 1'b0);
        checkOutput("b1_data", inData, 96'h2072616C6C69702065687420);
        tick();
        checkOutput("b1_offer", newData, 1'b1);
        tick();
        tick();
        loadData = 1'b1;
        @(negedge clk);
        checkOutput("b1_hold_until_load", newData, 1'b1);
        tick();
        loadData = 1'b0;
        checkOutput("b1_gap", newData, 1'b0);
        checkOutput("b1_released", blk_pending, 1'b0);
        tick();
        checkOutput("b1_idle_after_gap", newData, 1'b0);

        // Continuous stream with no consumer: back-pressure after byte 24.
        pulseReset();
        sendBlock(expBlock(0), 0, 12, 0);
        sendBlock(expBlock(1), 0, 12, 0);
        checkOutput("bp_ready_low", byte_ready, 1'b0);
        checkOutput("bp_fill", fill_count, 4'd11);
        checkOutput("bp_offer", newData, 1'b1);
        checkOutput("bp_held", inData, 96'h000102030405060708090A0B);
        byte_in    = 8'h20;
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_stall_fill", fill_count, 4'd11);
        end
        loadData = 1'b1;
        tick();
        loadData   = 1'b0;
        byte_valid = 1'b0;
        checkOutput("bp_gap", newData, 1'b0);
        checkOutput("bp_block2", inData, 96'h101112131415161718191A1B);
        checkOutput("bp_byte25", fill_count, 4'd1);
        checkOutput("bp_pending", blk_pending, 1'b1);
        tick();
        checkOutput("bp_reoffer", newData, 1'b1);
        fork
            begin
                sendBlock(expBlock(2), 1, 11, 0);
                sendBlock(expBlock(3), 0, 12, 0);
                sendBlock(expBlock(4), 0, 12, 0);
            end
            begin
                for (int k = 1; k < 5; k++) begin
                    waitOffer("bp_wait_offer");
                    checkOutput("bp_stream_block", inData, expBlock(k));
                    tick();
                    loadData = 1'b1;
                    tick();
                    loadData = 1'b0;
                end
            end
        join
        checkOutput("bp_drained_pending", blk_pending, 1'b0);
        checkOutput("bp_drained_fill", fill_count, 4'd0);

        // Last byte of the next block lands on the releasing edge.
        pulseReset();
        sendBlock(96'h0123456789ABCDEF02468ACE, 0, 12, 0);
        sendBlock(96'hA8D5F7DE0123FEDC01234567, 0, 11, 0);
        checkOutput("same_edge_offer1", newData, 1'b1);
        checkOutput("same_edge_data1", inData, 96'h0123456789ABCDEF02468ACE);
        loadData = 1'b1;
        applyStimulus(8'h67);
        loadData   = 1'b0;
        byte_valid = 1'b0;
        checkOutput("same_edge_gap", newData, 1'b0);
        checkOutput("same_edge_data2", inData, 96'hA8D5F7DE0123FEDC01234567);
        checkOutput("same_edge_pending", blk_pending, 1'b1);
        checkOutput("same_edge_fill", fill_count, 4'd0);
        tick();
        checkOutput("same_edge_reoffer", newData, 1'b1);
        checkOutput("same_edge_stable", inData, 96'hA8D5F7DE0123FEDC01234567);
        loadData = 1'b1;
        tick();
        loadData = 1'b0;

        // Reset in the middle of a block while another block is on offer.
        pulseReset();
        sendBlock(expBlock(7), 0, 12, 0);
        waitOffer("mid_rst_offer");
        tick();
        sendBlock(expBlock(8), 0, 5, 0);
        checkOutput("mid_rst_fill5", fill_count, 4'd5);
        #2 nR = 1'b0;
        #1;
        checkOutput("mid_rst_inData", inData, 96'h0);
        checkOutput("mid_rst_newData", newData, 1'b0);
        checkOutput("mid_rst_fill", fill_count, 4'd0);
        checkOutput("mid_rst_pending", blk_pending, 1'b0);
        checkOutput("mid_rst_ready", byte_ready, 1'b1);
        #2 nR = 1'b1;
        tick();
        checkOutput("mid_rst_quiet1", newData, 1'b0);
        tick();
        checkOutput("mid_rst_quiet2", newData, 1'b0);
        sendBlock(expBlock(9), 0, 12, 0);
        waitOffer("post_rst_offer");
        checkOutput("post_rst_block", inData, expBlock(9));
        tick();
        loadData = 1'b1;
        tick();
        loadData = 1'b0;

        // loadData with nothing on offer must be ignored.
        pulseReset();
        sendBlock(expBlock(5), 0, 3, 0);
        loadData = 1'b1;
        tick();
        tick();
        loadData = 1'b0;
        checkOutput("ign_fill", fill_count, 4'd3);
        checkOutput("ign_newData", newData, 1'b0);
        checkOutput("ign_pending", blk_pending, 1'b0);
        sendBlock(expBlock(5), 3, 9, 0);
        checkOutput("ign_idle_pending", blk_pending, 1'b1);
        loadData = 1'b1;
        tick();
        checkOutput("ign_idle_offer", newData, 1'b1);
        checkOutput("ign_idle_kept", blk_pending, 1'b1);
        checkOutput("ign_idle_data", inData, expBlock(5));
        loadData = 1'b0;
        loadData = 1'b1;
        tick();
        loadData = 1'b0;
        checkOutput("ign_release", newData, 1'b0);

        // Randomised byte gaps and consumer delays against a scoreboard.
        pulseReset();
        rise0 = riseCount;
        fork
            begin
                for (int b = 0; b < 100; b++) begin
                    rndBlk = {$urandom, $urandom, $urandom};
                    expQ.push_back(rndBlk);
                    sendBlock(rndBlk, 0, 12, 1);
                end
            end
            begin
                for (int c = 0; c < 100; c++) begin
                    waitOffer("rnd_offer");
                    if (expQ.size() == 0) begin
                        reportTimeout("rnd_queue");
                        held = '0;
                    end else begin
                        held = expQ.pop_front();
                    end
                    checkOutput("rnd_block", inData, held);
                    repeat ($urandom_range(0, 14)) begin
                        @(negedge clk);
                        checkOutput("rnd_stable", inData, held);
                    end
                    tick();
                    loadData = 1'b1;
                    tick();
                    loadData = 1'b0;
                    checkOutput("rnd_gap", newData, 1'b0);
                end
            end
        join
        checkOutput("rnd_rises", riseCount - rise0, 96'd100);
        checkOutput("rnd_end_pending", blk_pending, 1'b0);
        checkOutput("rnd_end_fill", fill_count, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
